i2c_config_sequencer: RTL and testbench

- Table-driven I2C register-configuration sequencer. Generalised successor to the fixed HDMI config queue.
- Walks a parametrised-depth entry table held in an external synchronous ROM and issues write transactions to the I2C byte-write controller.
- Supports entry types WRITE, DELAY and END, configurable data-byte count, and NACK retry with a limit.
- Sits between a start source (single-shot pulse) and the I2C controller, running on the I2C tick clock domain.

---
 rtl/i2c_config_sequencer_if.sv | 22 ++
 rtl/i2c_config_sequencer.sv | 118 +++++++++++
 tb/tb_i2c_config_sequencer.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_config_sequencer_if.sv
// i2c_config_sequencer_if: table ROM and I2C byte-write controller bus of the config sequencer
interface i2c_config_sequencer_if #(
    parameter int IDX_W = 5,
    parameter int DATA_BYTES = 2
);
    localparam int ENTRY_W = 2 + 7 + 8 * DATA_BYTES;
    logic [IDX_W-1:0] rom_index;
    logic [ENTRY_W-1:0] rom_data;
    logic i2c_busy;
    logic i2c_nack;
    logic i2c_start;
    logic [6:0] address;
    logic [8*DATA_BYTES-1:0] data;
    modport master (
        output rom_index, i2c_start, address, data,
        input rom_data, i2c_busy, i2c_nack
    );
    modport slave (
        input rom_index, i2c_start, address, data,
        output rom_data, i2c_busy, i2c_nack
    );
endinterface

// File: rtl/i2c_config_sequencer.sv
// i2c_config_sequencer: walks a ROM table of WRITE/DELAY/END entries, issuing I2C writes
// with NACK/timeout retry and reporting done or the index of the entry that failed.
module i2c_config_sequencer #(
    parameter int NUM_ENTRIES = 32,
    parameter int DATA_BYTES = 2,
    parameter int DELAY_W = 16,
    parameter int MAX_RETRIES = 3,
    parameter int BUSY_TIMEOUT = 8,
    localparam int IDX_W = $clog2(NUM_ENTRIES)
) (
    input logic clk,
    input logic rst,
    input logic start,
    i2c_config_sequencer_if.master bus,
    output logic busy,
    output logic done,
    output logic error,
    output logic [IDX_W-1:0] err_index
);
    localparam int PW = 8 * DATA_BYTES;
    localparam int ENTRY_W = 2 + 7 + PW;
    localparam int RW = $clog2(MAX_RETRIES + 1);
    localparam int TW = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_DELAY = 2'b01;
    localparam logic [1:0] OP_END = 2'b10;
    typedef enum logic [3:0] {IDLE, FETCH, DECODE, ISSUE, WAIT_HI, WAIT_LO, DELAY, DONE, ERROR} state_t;
    state_t state;
    logic [PW+6:0] wr;
    logic [RW-1:0] retry;
    logic [TW-1:0] tcnt;
    logic [DELAY_W-1:0] dcnt;
    logic [1:0] op;
    logic [DELAY_W-1:0] dly;
    logic adv, fail, last;
    // tcnt counts from the i2c_start cycle, so timed-out attempts re-issue BUSY_TIMEOUT cycles apart
    always_comb begin
        op = bus.rom_data[ENTRY_W-1 -: 2];
        dly = bus.rom_data[DELAY_W-1:0];
        last = bus.rom_index == IDX_W'(NUM_ENTRIES - 1);
        adv = (state == WAIT_LO && !bus.i2c_busy && !bus.i2c_nack)
            || (state == DECODE && op == OP_DELAY && dly == '0)
            || (state == DELAY && dcnt == DELAY_W'(1));
        fail = !bus.i2c_busy && ((state == WAIT_LO && bus.i2c_nack)
            || (state == WAIT_HI && tcnt == TW'(BUSY_TIMEOUT - 1)));
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            bus.rom_index <= '0;
            bus.i2c_start <= 1'b0;
            bus.address <= '0;
            bus.data <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            error <= 1'b0;
            err_index <= '0;
            wr <= '0;
            retry <= '0;
            tcnt <= '0;
            dcnt <= '0;
        end else begin
            bus.i2c_start <= 1'b0;
            if (adv) begin
                retry <= '0;
                if (last) begin
                    state <= DONE;
                    busy <= 1'b0;
                    done <= 1'b1;
                end else begin
                    bus.rom_index <= bus.rom_index + 1'b1;
                    state <= FETCH;
                end
            end else if (fail) begin
                if (retry == RW'(MAX_RETRIES)) begin
                    state <= ERROR;
                    busy <= 1'b0;
                    error <= 1'b1;
                    err_index <= bus.rom_index;
                end else begin
                    retry <= retry + 1'b1;
                    state <= ISSUE;
                end
            end else begin
                case (state)
                    IDLE, DONE, ERROR: if (start) begin
                        state <= FETCH;
                        busy <= 1'b1;
                        done <= 1'b0;
                        error <= 1'b0;
                        bus.rom_index <= '0;
                        retry <= '0;
                    end
                    FETCH: state <= DECODE;
                    DECODE: begin
                        wr <= bus.rom_data[ENTRY_W-3:0];
                        dcnt <= dly;
                        state <= op == OP_WRITE ? ISSUE : op == OP_DELAY ? DELAY : op == OP_END ? DONE : ERROR;
                        busy <= !op[1];
                        done <= op == OP_END;
                        error <= op == 2'b11;
                        if (op == 2'b11) err_index <= bus.rom_index;
                    end
                    ISSUE: begin
                        bus.address <= wr[PW+6:PW];
                        bus.data <= wr[PW-1:0];
                        bus.i2c_start <= 1'b1;
                        tcnt <= TW'(1);
                        state <= WAIT_HI;
                    end
                    WAIT_HI: if (bus.i2c_busy) state <= WAIT_LO; else tcnt <= tcnt + 1'b1;
                    DELAY: dcnt <= dcnt - 1'b1;
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_i2c_config_sequencer.sv
// tb_i2c_config_sequencer: scoreboard bench; a table-walking reference model predicts every
// i2c_start transaction and the final done/error, and a negedge monitor checks them.
module tb_i2c_config_sequencer;
    localparam int BT = 8;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic busy, done, error;
    logic [1:0] err_index;
    int cyc = 0, n_chk = 0, n_fail = 0, s_edge = 0, last_pulse = 0, blen = 4, mode = 0, bcnt = 0;
    int gap0, gap1, n;
    bit pend, prev_start, prev_done, prev_err;
    logic [24:0] tbl [4];
    int resp [$];
    int pcyc [$];
    typedef struct {int kind; logic [6:0] addr; logic [15:0] data; int idx; int lat; bit from_start;} exp_t;
    exp_t exp_q [$];
    exp_t e;

    i2c_config_sequencer_if #(.IDX_W(2), .DATA_BYTES(2)) bus ();

    i2c_config_sequencer #(
        .NUM_ENTRIES(4), .DATA_BYTES(2), .DELAY_W(16), .MAX_RETRIES(3), .BUSY_TIMEOUT(BT)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .bus(bus),
        .busy(busy), .done(done), .error(error), .err_index(err_index)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) bus.rom_data <= tbl[bus.rom_index];

    // controller: per transaction pops 0=ACK, 1=NACK, 2=never raises busy
    always @(posedge clk) begin
        if (rst) begin
            bus.i2c_busy <= 1'b0;
            bus.i2c_nack <= 1'b0;
            bcnt <= 0;
        end else if (bus.i2c_busy) begin
            if (bcnt == 1) begin
                bus.i2c_busy <= 1'b0;
                bus.i2c_nack <= pend;
            end
            bcnt <= bcnt - 1;
        end else if (bus.i2c_start) begin
            mode = resp.size() > 0 ? resp.pop_front() : 0;
            if (mode != 2) begin
                bus.i2c_busy <= 1'b1;
                bus.i2c_nack <= 1'b0;
                bcnt <= blen;
                pend <= mode == 1;
            end
        end
    end

    task automatic chk(input bit ok, input string nm, input longint act, input longint expv);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, expv);
        end
    endtask

    function automatic logic [24:0] ent(input logic [1:0] op, input logic [6:0] a, input logic [15:0] d);
        return {op, a, d};
    endfunction

    function automatic void push(input int kind, input logic [6:0] a, input logic [15:0] d,
                                 input int idx, input int lat, input bit fs);
        exp_t x;
        x.kind = kind; x.addr = a; x.data = d; x.idx = idx; x.lat = lat; x.from_start = fs;
        exp_q.push_back(x);
    endfunction

    // reference: walk the table entry by entry, consuming one controller response per write attempt
    function automatic void model();
        int idx, retry, k, r;
        bit to;
        logic [24:0] en;
        idx = 0; retry = 0; k = 0; to = 0;
        forever begin
            en = tbl[idx];
            if (en[24:23] == 2'b10) begin push(1, 7'h0, 16'h0, idx, -1, 1'b0); break; end
            if (en[24:23] == 2'b11) begin push(2, 7'h0, 16'h0, idx, -1, 1'b0); break; end
            if (en[24:23] == 2'b00) begin
                push(0, en[22:16], en[15:0], idx, (idx == 0 && retry == 0) ? 3 : to ? BT : -1,
                     idx == 0 && retry == 0);
                r = k < resp.size() ? resp[k] : 0;
                k++;
                to = r == 2;
                if (r != 0) begin
                    if (retry == 3) begin push(2, 7'h0, 16'h0, idx, -1, 1'b0); break; end
                    retry++;
                    continue;
                end
            end
            retry = 0;
            to = 0;
            if (idx == 3) begin push(1, 7'h0, 16'h0, idx, -1, 1'b0); break; end
            idx++;
        end
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            prev_start = 1'b0; prev_done = 1'b0; prev_err = 1'b0;
        end else begin
            if (bus.i2c_start) begin
                chk(prev_start == 1'b0, "start_width", prev_start + 1, 1);
                pcyc.push_back(cyc);
                chk(exp_q.size() > 0, "start_expected", exp_q.size(), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk(e.kind == 0, "start_kind", 0, e.kind);
                    chk(bus.address == e.addr, "address", bus.address, e.addr);
                    chk(bus.data == e.data, "data", bus.data, e.data);
                    if (e.lat >= 0)
                        chk(cyc - (e.from_start ? s_edge : last_pulse) == e.lat, "start_latency",
                            cyc - (e.from_start ? s_edge : last_pulse), e.lat);
                end
                last_pulse = cyc;
            end
            if ((done && !prev_done) || (error && !prev_err)) begin
                chk(exp_q.size() > 0, "end_expected", exp_q.size(), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk((done ? 1 : 2) == e.kind, "end_kind", done ? 1 : 2, e.kind);
                    chk(!busy, "busy_at_end", busy, 0);
                    if (e.kind == 2) chk(err_index == e.idx, "err_index", err_index, e.idx);
                end
            end
            prev_start = bus.i2c_start; prev_done = done; prev_err = error;
        end
    end

    task automatic launch();
        pcyc.delete();
        model();
        @(negedge clk);
        start = 1'b1;
        s_edge = cyc + 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_seq(input bit mid, input int budget);
        int k;
        launch();
        if (mid) begin
            repeat (6) @(negedge clk);
            chk(busy, "busy_mid", busy, 1);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        k = 0;
        while (!(done || error) && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(k < budget, "seq_finish", k, budget);
        repeat (30) @(negedge clk);
        chk(exp_q.size() == 0, "exp_left", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        for (int j = 0; j < 4; j++) tbl[j] = ent(2'd2, 7'h0, 16'h0);
        repeat (3) @(negedge clk);
        chk({busy, done, error, err_index, bus.i2c_start, bus.address, bus.data, bus.rom_index} == 0,
            "reset_outputs", {busy, done, error, err_index, bus.i2c_start, bus.address, bus.data, bus.rom_index}, 0);
        rst = 1'b0;
        @(negedge clk);
        chk(!busy && !done, "idle_state", {busy, done}, 0);

        tbl[0] = ent(2'd0, 7'h39, 16'h4110);
        tbl[1] = ent(2'd0, 7'h39, 16'h9803);
        tbl[2] = ent(2'd2, 7'h0, 16'h0);
        resp.delete(); blen = 20;
        run_seq(1'b1, 500);
        chk(pcyc.size() == 2, "basic_pulses", pcyc.size(), 2);
        chk(done && !error && !busy, "basic_status", {done, error, busy}, 3'b100);

        tbl[0] = ent(2'd0, 7'h10, 16'h0001);
        tbl[1] = ent(2'd1, 7'h0, 16'd0);
        tbl[2] = ent(2'd0, 7'h11, 16'h0002);
        tbl[3] = ent(2'd2, 7'h0, 16'h0);
        resp.delete(); blen = 4;
        run_seq(1'b0, 500);
        gap0 = pcyc.size() == 2 ? pcyc[1] - pcyc[0] : 0;
        tbl[1] = ent(2'd1, 7'h0, 16'd5);
        run_seq(1'b0, 500);
        gap1 = pcyc.size() == 2 ? pcyc[1] - pcyc[0] : 0;
        chk(pcyc.size() == 2 && gap1 == gap0 + 5, "delay5_gap", gap1, gap0 + 5);

        tbl[0] = ent(2'd0, 7'h2a, 16'hbeef);
        tbl[1] = ent(2'd2, 7'h0, 16'h0);
        resp = {1, 0};
        run_seq(1'b0, 500);
        chk(pcyc.size() == 2, "retry_pulses", pcyc.size(), 2);
        chk(done && !error, "retry_status", {done, error}, 2'b10);

        tbl[0] = ent(2'd0, 7'h20, 16'h1111);
        resp = {2, 2, 2, 2};
        run_seq(1'b0, 500);
        chk(pcyc.size() == 4, "timeout_pulses", pcyc.size(), 4);
        chk(error && !done && err_index == 2'd0, "timeout_status", {error, done, err_index}, 4'b1000);

        tbl[0] = ent(2'd0, 7'h21, 16'h0a0a);
        tbl[1] = ent(2'd0, 7'h22, 16'h0b0b);
        tbl[2] = ent(2'd0, 7'h23, 16'h0c0c);
        tbl[3] = ent(2'd2, 7'h0, 16'h0);
        resp = {0, 0, 1, 1, 1, 1};
        run_seq(1'b0, 500);
        chk(pcyc.size() == 6, "nack_pulses", pcyc.size(), 6);
        chk(error && !done && err_index == 2'd2, "nack_status", {error, done, err_index}, 4'b1010);

        tbl[0] = ent(2'd0, 7'h55, 16'h1234);
        tbl[1] = ent(2'd0, 7'h56, 16'h5678);
        tbl[2] = ent(2'd2, 7'h0, 16'h0);
        resp.delete(); blen = 20;
        launch();
        n = 0;
        while (!bus.i2c_busy && n < 40) begin @(negedge clk); n++; end
        chk(n < 40, "rst_wait_busy", n, 40);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk({busy, done, error, err_index, bus.i2c_start, bus.address, bus.data, bus.rom_index} == 0,
            "midrst_outputs", {busy, done, error, err_index, bus.i2c_start, bus.address, bus.data, bus.rom_index}, 0);
        rst = 1'b0;
        exp_q.delete();
        run_seq(1'b0, 500);
        chk(pcyc.size() == 2 && done, "rerun_after_rst", pcyc.size(), 2);

        for (int j = 0; j < 4; j++) tbl[j] = ent(2'd0, 7'(7'h40 + j), 16'(16'h100 * j + 16'h1));
        resp.delete(); blen = 3;
        run_seq(1'b0, 500);
        chk(pcyc.size() == 4, "noend_pulses", pcyc.size(), 4);
        chk(done && bus.rom_index == 2'd3, "noend_index", bus.rom_index, 3);

        for (int it = 0; it < 25; it++) begin
            int r;
            logic [1:0] op;
            for (int j = 0; j < 4; j++) begin
                r = $urandom_range(0, 9);
                op = r < 6 ? 2'd0 : r < 8 ? 2'd1 : r < 9 ? 2'd2 : 2'd3;
                tbl[j] = ent(op, 7'($urandom), op == 2'd1 ? 16'($urandom_range(0, 6)) : 16'($urandom));
            end
            resp.delete();
            for (int j = 0; j < 16; j++) begin
                r = $urandom_range(0, 9);
                resp.push_back(r < 6 ? 0 : r < 9 ? 1 : 2);
            end
            blen = $urandom_range(1, 6);
            run_seq(1'b0, 2000);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
